// File: rtl/muldiv_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_ctrl
// Description : Iterative 32x32 multiply / divide unit with HI/LO registers.
//               It takes 34 cycles from accepting an operation to Done_out.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start_in,
    input  logic [1:0]  Op_in,
    input  logic [31:0] A_in,
    input  logic [31:0] B_in,
    input  logic        HiWe_in,
    input  logic        LoWe_in,
    output logic        Busy_out,
    output logic        Done_out,
    output logic [31:0] Hi_out,
    output logic [31:0] Lo_out
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FIXUP = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [4:0]  cnt;
    logic [63:0] acc;
    logic [31:0] opnd;
    logic        is_div;
    logic        sign_a;
    logic        sign_b;
    logic        b_zero;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        done;

    logic        a_neg_in;
    logic        b_neg_in;
    logic [31:0] a_abs;
    logic [31:0] b_abs;
    logic [32:0] mul_sum;
    logic [32:0] rem_sh;
    logic        no_borrow;
    logic [31:0] diff;
    logic [63:0] step_acc;
    logic        neg;
    logic [63:0] prod_fix;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (Start_in) state_nxt = RUN;
            RUN:     if (cnt == 5'd31) state_nxt = FIXUP;
            FIXUP:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        a_neg_in = ~Op_in[0] & A_in[31];
        b_neg_in = ~Op_in[0] & B_in[31];
        a_abs    = a_neg_in ? (~A_in + 32'd1) : A_in;
        b_abs    = b_neg_in ? (~B_in + 32'd1) : B_in;

        // Multiply: acc = {partial, multiplier}, shift right after each add.
        mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);

        // Divide: acc = {remainder, dividend/quotient}, shift left each step.
        // The shifted remainder needs 33 bits when the divisor exceeds 2^31.
        rem_sh    = acc[63:31];
        no_borrow = (rem_sh >= {1'b0, opnd});
        diff      = rem_sh[31:0] - opnd;

        if (is_div)
            step_acc = no_borrow ? {diff, acc[30:0], 1'b1}
                                 : {rem_sh[31:0], acc[30:0], 1'b0};
        else
            step_acc = {mul_sum, acc[31:1]};

        neg      = sign_a ^ sign_b;
        prod_fix = neg ? (~acc + 64'd1) : acc;
        quo_fix  = neg ? (~acc[31:0] + 32'd1) : acc[31:0];
        rem_fix  = sign_a ? (~acc[63:32] + 32'd1) : acc[63:32];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt    <= 5'd0;
            acc    <= 64'd0;
            opnd   <= 32'd0;
            is_div <= 1'b0;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            b_zero <= 1'b0;
            hi     <= 32'd0;
            lo     <= 32'd0;
            done   <= 1'b0;
        end else begin
            done <= (state == FIXUP);
            case (state)
                IDLE: begin
                    if (Start_in) begin
                        is_div <= Op_in[1];
                        sign_a <= a_neg_in;
                        sign_b <= b_neg_in;
                        b_zero <= (B_in == 32'd0);
                        cnt    <= 5'd0;
                        opnd   <= Op_in[1] ? b_abs : a_abs;
                        acc    <= {32'd0, (Op_in[1] ? a_abs : b_abs)};
                    end else begin
                        if (HiWe_in) hi <= A_in;
                        if (LoWe_in) lo <= A_in;
                    end
                end
                RUN: begin
                    acc <= step_acc;
                    cnt <= cnt + 5'd1;
                end
                FIXUP: begin
                    // A zero divisor leaves HI/LO untouched.
                    if (!is_div) begin
                        hi <= prod_fix[63:32];
                        lo <= prod_fix[31:0];
                    end else if (!b_zero) begin
                        hi <= rem_fix;
                        lo <= quo_fix;
                    end
                end
                default: ;
            endcase
        end
    end

    assign Busy_out = (state != IDLE);
    assign Done_out = done;
    assign Hi_out   = hi;
    assign Lo_out   = lo;

endmodule
`default_nettype wire
